// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined LC-3b core.
// The next-PC mux and the PC/DE load enables are combinational.
// The F->DE pipeline latch is the only state in this block.
module fetch_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic        imem_r,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  input  logic [15:0] instr,
  output logic        ld_pc,
  output logic [15:0] new_pc,
  output logic        ld_de,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
);

  localparam logic [1:0] PCMUX_SEQ    = 2'd0;
  localparam logic [1:0] PCMUX_TARGET = 2'd1;
  localparam logic [1:0] PCMUX_TRAP   = 2'd2;

  logic [15:0] w_pc_plus2;
  logic        w_br_stall;
  logic        w_redirect;
  logic        w_seq_advance;

  logic [15:0] r_de_npc;
  logic [15:0] r_de_ir;
  logic        r_de_v;

  // The add wraps naturally, so FFFE + 2 gives 0000.
  assign w_pc_plus2 = pc + 16'd2;

  // A control-flow instruction anywhere downstream blocks sequential fetch.
  assign w_br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;

  // A MEM redirect goes ahead whenever MEM itself is not stalled.
  // A redirect therefore wins over a dependency stall or a branch stall.
  assign w_redirect    = (mem_pcmux != PCMUX_SEQ) & ~mem_stall;
  assign w_seq_advance = imem_r & ~dep_stall & ~mem_stall & ~w_br_stall;

  assign ld_pc = w_redirect | w_seq_advance;
  assign ld_de = ~(dep_stall | mem_stall);

  // Select the next PC. The reserved select value 3 behaves as sequential.
  always_comb begin
    new_pc = w_pc_plus2;
    case (mem_pcmux)
      PCMUX_TARGET: new_pc = target_pc;
      PCMUX_TRAP:   new_pc = trap_pc;
      default:      new_pc = w_pc_plus2;
    endcase
  end

  // DE latch: reset has priority over load. The latch holds its value when ld_de is low.
  // When a branch is in flight or imem is not ready, DE receives a bubble.
  // The npc and ir fields are still captured for that bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_de_npc <= 16'h0000;
      r_de_ir  <= 16'h0000;
      r_de_v   <= 1'b0;
    end else if (ld_de) begin
      r_de_npc <= w_pc_plus2;
      r_de_ir  <= instr;
      r_de_v   <= imem_r & ~w_br_stall;
    end
  end

  assign de_npc = r_de_npc;
  assign de_ir  = r_de_ir;
  assign de_v   = r_de_v;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// It runs directed cases from the fetch-stage rules and then randomized cycles.
// Every cycle is checked against a behavioural model held in the bench.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic        dep_stall, mem_stall;
  logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
  logic        imem_r;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc, trap_pc, instr;
  logic        ld_pc, ld_de, de_v;
  logic [15:0] new_pc, de_npc, de_ir;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the DE latch contents.
  logic [15:0] m_npc, m_ir;
  logic        m_v;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .imem_r(imem_r),
    .mem_pcmux(mem_pcmux), .target_pc(target_pc), .trap_pc(trap_pc),
    .instr(instr), .ld_pc(ld_pc), .new_pc(new_pc), .ld_de(ld_de),
    .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the combinational outputs against the model.
  // Then it clocks once, advances the model latch and checks the latch outputs.
  task automatic step();
    logic [15:0] pp2, e_new_pc;
    logic        any_br, e_ld_pc, e_ld_de;
    pp2      = pc + 16'd2;
    any_br   = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
    e_new_pc = (mem_pcmux == 2'd1) ? target_pc :
               (mem_pcmux == 2'd2) ? trap_pc : pp2;
    e_ld_pc  = (mem_pcmux != 2'd0 && !mem_stall) ||
               (imem_r && !dep_stall && !mem_stall && !any_br);
    e_ld_de  = !(dep_stall || mem_stall);
    #1;
    check_val("new_pc", new_pc, e_new_pc);
    check_val("ld_pc", {15'd0, ld_pc}, {15'd0, e_ld_pc});
    check_val("ld_de", {15'd0, ld_de}, {15'd0, e_ld_de});
    @(posedge clk);
    if (!reset_n) begin
      m_npc = 16'h0000; m_ir = 16'h0000; m_v = 1'b0;
    end else if (e_ld_de) begin
      m_npc = pp2; m_ir = instr; m_v = imem_r && !any_br;
    end
    #1;
    check_val("de_npc", de_npc, m_npc);
    check_val("de_ir", de_ir, m_ir);
    check_val("de_v", {15'd0, de_v}, {15'd0, m_v});
  endtask

  task automatic setup();
    reset_n = 1'b1; pc = 16'h3000; target_pc = 16'hDEAD; trap_pc = 16'hBEEF;
    instr = 16'hABCD; imem_r = 1'b1; dep_stall = 1'b0; mem_stall = 1'b0;
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
    mem_pcmux = 2'd0;
  endtask

  initial begin
    setup();
    reset_n = 1'b0;
    step();
    check_val("reset_de_v", {15'd0, de_v}, 16'd0);
    check_val("reset_de_npc", de_npc, 16'h0000);

    // Sequential fetch.
    setup();
    step();
    check_val("seq_de_npc", de_npc, 16'h3002);
    check_val("seq_de_ir", de_ir, 16'hABCD);
    check_val("seq_de_v", {15'd0, de_v}, 16'd1);

    // Redirect selects, the reserved select value, and PC wraparound.
    for (int s = 1; s < 4; s++) begin
      setup(); mem_pcmux = s[1:0]; step();
    end
    setup(); mem_pcmux = 2'd2; #1;
    check_val("trap_new_pc", new_pc, 16'hBEEF);
    setup(); pc = 16'hFFFE; #1;
    check_val("wrap_new_pc", new_pc, 16'h0000);
    step();

    // Dependency stall with a redirect: PC loads and the latch holds.
    setup(); instr = 16'h1111; step();
    dep_stall = 1'b1; mem_pcmux = 2'd2; instr = 16'h2222; #1;
    check_val("dep_ld_pc", {15'd0, ld_pc}, 16'd1);
    step();
    check_val("dep_hold_ir", de_ir, 16'h1111);
    mem_stall = 1'b1; #1;
    check_val("mem_ld_pc", {15'd0, ld_pc}, 16'd0);
    step();

    // Each branch stall alone produces a bubble.
    for (int b = 0; b < 3; b++) begin
      setup();
      v_de_br_stall = (b == 0); v_agex_br_stall = (b == 1); v_mem_br_stall = (b == 2);
      step();
      check_val("br_bubble_v", {15'd0, de_v}, 16'd0);
      check_val("br_bubble_ir", de_ir, 16'hABCD);
    end

    // Instruction memory is not ready.
    setup(); imem_r = 1'b0; step();
    setup(); imem_r = 1'b0; mem_pcmux = 2'd1; step();

    // Reset asserted during a stall clears a valid latch.
    setup(); step();
    reset_n = 1'b0; dep_stall = 1'b1; step();
    check_val("rst_stall_ir", de_ir, 16'h0000);
    setup(); step();
    check_val("post_rst_v", {15'd0, de_v}, 16'd1);

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      reset_n         = ($urandom_range(0, 24) != 0);
      pc              = 16'($urandom);
      target_pc       = 16'($urandom);
      trap_pc         = 16'($urandom);
      instr           = 16'($urandom);
      mem_pcmux       = 2'($urandom);
      imem_r          = ($urandom_range(0, 3) != 0);
      dep_stall       = ($urandom_range(0, 4) == 0);
      mem_stall       = ($urandom_range(0, 4) == 0);
      v_de_br_stall   = ($urandom_range(0, 5) == 0);
      v_agex_br_stall = ($urandom_range(0, 5) == 0);
      v_mem_br_stall  = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
